// File: rtl/mem_pkg.sv
// mem_pkg: FSM state encoding and R_W constants for the memory-fetch handshake
package mem_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port word array, synchronous write, registered read
module mem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;
    // contents are deliberately never reset so they survive a reset pulse
    always_ff @(posedge clk) begin
        if (en_i && we_i) mem_q[addr_i] <= wdata_i;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else if (en_i && !we_i) rdata_q <= mem_q[addr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: EN/MFC handshake responder with fixed wait states in front of mem_array
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    input  logic              R_W,
    input  logic              EN,
    output logic              MFC
);
    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rw_q;
    logic              mfc_q;
    logic              access;
    logic              unused_addr;
    // the array port fires only on a completion edge that is not being aborted
    assign access      = state_q == BUSY && EN && cnt_q == 4'd0;
    assign unused_addr = ^address;
    assign MFC         = mfc_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mfc_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= RD;
        end else begin
            case (state_q)
                IDLE: if (EN) begin
                    addr_q  <= address[ADDR_W-1:0];
                    wdata_q <= data_in;
                    rw_q    <= R_W;
                    cnt_q   <= 4'(WAIT_CYCLES);
                    state_q <= BUSY;
                end
                BUSY: if (!EN) state_q <= IDLE;
                else if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                else begin
                    state_q <= DONE;
                    mfc_q   <= 1'b1;
                end
                DONE: if (!EN) begin
                    state_q <= IDLE;
                    mfc_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
        .clk    (clk),
        .rst_n  (reset),
        .en_i   (access),
        .we_i   (rw_q == WR),
        .addr_i (addr_q),
        .wdata_i(wdata_q),
        .rdata_o(data_out)
    );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: vector table, corner sequences and random traffic against a word-array model
module tb_mem_responder;
    import mem_pkg::*;
    localparam int W0 = 2;
    localparam int W1 = 0;
    logic        clk = 1'b0;
    logic        rst_n [2];
    logic [15:0] addr  [2];
    logic [15:0] din   [2];
    logic [15:0] dout  [2];
    logic        rw    [2];
    logic        en    [2];
    logic        mfc   [2];
    int passed = 0;
    int total  = 0;
    logic [15:0] mm [2][256];
    bit          mv [2][256];
    logic [15:0] dm [2];
    typedef struct {
        int          d;
        logic        r;
        logic [15:0] a;
        logic [15:0] dat;
        logic [15:0] exp;
    } vec_t;
    vec_t v [11];
    always #5 clk = ~clk;
    mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(W0)) u0 (
        .clk(clk), .reset(rst_n[0]), .address(addr[0]), .data_in(din[0]),
        .data_out(dout[0]), .R_W(rw[0]), .EN(en[0]), .MFC(mfc[0]));
    mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(W1)) u1 (
        .clk(clk), .reset(rst_n[1]), .address(addr[1]), .data_in(din[1]),
        .data_out(dout[1]), .R_W(rw[1]), .EN(en[1]), .MFC(mfc[1]));
    function automatic int wc(int d);
        return d == 0 ? W0 : W1;
    endfunction
    task automatic chk(string n, logic [15:0] a, logic [15:0] e);
        total++;
        if (a !== e) $display("FAIL %s: got %h expected %h", n, a, e);
        else passed++;
    endtask
    // full request; caller is at a negedge, returns at a negedge with EN low
    task automatic xact(int d, logic r, logic [15:0] a, logic [15:0] dat, bit scramble, int extra);
        int k;
        logic [7:0] ia;
        ia = a[7:0];
        rw[d] = r; addr[d] = a; din[d] = dat; en[d] = 1'b1;
        k = 0;
        do begin
            @(posedge clk); k++;
            @(negedge clk);
            if (scramble && k == 1) begin
                rw[d] = ~r; addr[d] = ~a; din[d] = ~dat;
            end
        end while (!mfc[d] && k < 40);
        chk("mfc_latency", 16'(k - 1), 16'(wc(d) + 1));
        if (r == WR) begin
            mm[d][ia] = dat; mv[d][ia] = 1'b1;
        end else if (mv[d][ia]) dm[d] = mm[d][ia];
        chk(r == RD ? "read_data" : "dout_after_write", dout[d], dm[d]);
        repeat (extra) begin
            @(posedge clk); @(negedge clk);
            chk("mfc_hold", 16'(mfc[d]), 16'd1);
            chk("dout_hold", dout[d], dm[d]);
        end
        en[d] = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("mfc_fall", 16'(mfc[d]), 16'd0);
    endtask
    // EN held for h accepting/wait edges, then dropped before completion
    task automatic abort_req(int d, logic r, logic [15:0] a, logic [15:0] dat, int h);
        rw[d] = r; addr[d] = a; din[d] = dat; en[d] = 1'b1;
        repeat (h) begin
            @(posedge clk); @(negedge clk);
            chk("abort_no_mfc", 16'(mfc[d]), 16'd0);
        end
        en[d] = 1'b0;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            chk("abort_mfc_low", 16'(mfc[d]), 16'd0);
            chk("abort_dout", dout[d], dm[d]);
        end
    endtask
    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; en[d] = 1'b0; rw[d] = RD; addr[d] = '0; din[d] = '0; dm[d] = '0;
        end
        v[0]  = '{0, WR, 16'h0001, 16'h0003, 16'h0000};
        v[1]  = '{0, RD, 16'h0001, 16'h0000, 16'h0003};
        v[2]  = '{0, WR, 16'h0002, 16'h2222, 16'h0000};
        v[3]  = '{0, WR, 16'h0007, 16'h0000, 16'h0000};
        v[4]  = '{0, WR, 16'h0009, 16'h5555, 16'h0000};
        v[5]  = '{0, WR, 16'h0102, 16'h1234, 16'h0000};
        v[6]  = '{0, RD, 16'h0002, 16'h0000, 16'h1234};
        v[7]  = '{1, WR, 16'h0005, 16'h0011, 16'h0000};
        v[8]  = '{1, RD, 16'h0005, 16'h0000, 16'h0011};
        v[9]  = '{1, WR, 16'h0005, 16'h0022, 16'h0000};
        v[10] = '{1, RD, 16'h0005, 16'h0000, 16'h0022};
        repeat (2) @(negedge clk);
        chk("reset_mfc0", 16'(mfc[0]), 16'd0);
        chk("reset_dout0", dout[0], 16'h0);
        chk("reset_mfc1", 16'(mfc[1]), 16'd0);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(negedge clk);
        foreach (v[i]) begin
            xact(v[i].d, v[i].r, v[i].a, v[i].dat, 1'b0, 0);
            if (v[i].r == RD) chk("vec_exp", dout[v[i].d], v[i].exp);
        end
        abort_req(0, WR, 16'h0007, 16'hBEEF, 2);
        xact(0, RD, 16'h0007, 16'h0, 1'b0, 0);
        chk("abort_read7", dout[0], 16'h0000);
        abort_req(1, WR, 16'h0005, 16'hDEAD, 1);
        xact(1, RD, 16'h0005, 16'h0, 1'b0, 0);
        chk("abort_read5", dout[1], 16'h0022);
        xact(0, RD, 16'h0001, 16'h0, 1'b0, 0);
        rw[0] = WR; addr[0] = 16'h0009; din[0] = 16'hAAAA; en[0] = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n[0] = 1'b0;
        #1 chk("rst_busy_mfc", 16'(mfc[0]), 16'd0);
        chk("rst_busy_dout", dout[0], 16'h0000);
        en[0] = 1'b0; dm[0] = '0;
        @(negedge clk); rst_n[0] = 1'b1;
        xact(0, RD, 16'h0009, 16'h0, 1'b0, 0);
        chk("rst_read9", dout[0], 16'h5555);
        xact(0, RD, 16'h0001, 16'h0, 1'b0, 0);
        chk("rst_read1", dout[0], 16'h0003);
        rw[0] = RD; addr[0] = 16'h0002; en[0] = 1'b1;
        repeat (W0 + 2) @(posedge clk);
        @(negedge clk);
        chk("done_mfc", 16'(mfc[0]), 16'd1);
        #2 rst_n[0] = 1'b0;
        #1 chk("rst_done_mfc", 16'(mfc[0]), 16'd0);
        chk("rst_done_dout", dout[0], 16'h0000);
        en[0] = 1'b0; dm[0] = '0;
        @(negedge clk); rst_n[0] = 1'b1;
        xact(0, RD, 16'h0001, 16'h0, 1'b1, 5);
        chk("scramble_read1", dout[0], 16'h0003);
        xact(0, RD, 16'h0002, 16'h0, 1'b0, 0);
        chk("scramble_nowrite", dout[0], 16'h1234);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++)
                xact(d, WR, 16'(i), 16'($urandom), 1'b0, 0);
            for (int i = 0; i < 60; i++) begin
                logic [15:0] ra;
                int op;
                ra = {8'($urandom), 4'h0, 4'($urandom)};
                op = $urandom_range(0, 3);
                if (op < 2) xact(d, RD, ra, 16'($urandom), 1'($urandom), $urandom_range(0, 2));
                else if (op == 2) xact(d, WR, ra, 16'($urandom), 1'($urandom), $urandom_range(0, 2));
                else abort_req(d, 1'($urandom), ra, 16'($urandom), $urandom_range(1, wc(d) + 1));
            end
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
